// File: rtl/wb_regfile.sv
// wb_regfile
//
// Writeback stage and integer register file for the five-stage RV64I pipeline.
// Picks the writeback value (ALU result or extracted load data) and commits it
// into a 32 x 64 register file. Drives the decode stage's two combinational
// read ports with same-cycle write-to-read bypass. Also keeps a retired
// instruction counter and a sticky load-fault flag.
//
// Ports:
//   clk         pipeline clock, all state updates on the rising edge
//   reset       asynchronous active-high reset, clears all state
//   wb_valid    an instruction occupies the WB slot this cycle
//   regwrite    instruction writes RD
//   memtoreg    writeback source: 1 = load data, 0 = alures
//   alures      ALU result; effective address for loads
//   readmem     raw aligned doubleword from data memory
//   funct3      load width and sign (RISC-V encoding)
//   RD          destination register index
//   rs1, rs2    read port indices
//   readdata1/2 combinational read ports (x0 reads as zero)
//   wbdata      combinational writeback value for forwarding
//   instret     registered count of retired instructions
//   load_fault  registered sticky flag, set by a faulting load
module wb_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        regwrite,
    input  logic        memtoreg,
    input  logic [63:0] alures,
    input  logic [63:0] readmem,
    input  logic [2:0]  funct3,
    input  logic [4:0]  RD,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [63:0] readdata1,
    output logic [63:0] readdata2,
    output logic [63:0] wbdata,
    output logic [63:0] instret,
    output logic        load_fault
);

    logic [63:0] regs [32];
    logic [2:0]  byteOffset;
    logic [63:0] shiftedMem;
    logic [63:0] loadData;
    logic        misaligned;
    logic        fault;
    logic        writeEnable;

    assign byteOffset = alures[2:0];
    assign shiftedMem = readmem >> {byteOffset, 3'b000};

    // Load extraction: the addressed bytes are shifted down to bit 0 first,
    // so every width only has to look at the low bits. funct3[2] selects
    // zero extension; 011 and the illegal 111 both pass the full doubleword
    // (the latter faults anyway, so its data is don't-care).
    always_comb begin
        loadData = shiftedMem;
        case (funct3)
            3'b000:  loadData = {{56{shiftedMem[7]}},  shiftedMem[7:0]};
            3'b001:  loadData = {{48{shiftedMem[15]}}, shiftedMem[15:0]};
            3'b010:  loadData = {{32{shiftedMem[31]}}, shiftedMem[31:0]};
            3'b100:  loadData = {56'd0, shiftedMem[7:0]};
            3'b101:  loadData = {48'd0, shiftedMem[15:0]};
            3'b110:  loadData = {32'd0, shiftedMem[31:0]};
            default: loadData = shiftedMem;
        endcase
    end

    // Natural alignment check keyed on access size (funct3[1:0]); byte
    // accesses can never be misaligned.
    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = byteOffset[0];
            2'b10:   misaligned = |byteOffset[1:0];
            2'b11:   misaligned = |byteOffset;
            default: misaligned = 1'b0;
        endcase
    end

    // Fault only matters for loads; ALU writebacks ignore funct3 and offset.
    assign fault       = memtoreg & ((funct3 == 3'b111) | misaligned);
    assign wbdata      = memtoreg ? loadData : alures;
    assign writeEnable = wb_valid & regwrite & (RD != 5'd0) & ~fault;

    // Read ports: x0 is forced to zero; otherwise a matching same-cycle write
    // is bypassed. writeEnable already excludes RD==0, so the bypass can
    // never leak a value onto an x0 read.
    always_comb begin
        if (rs1 == 5'd0)
            readdata1 = 64'd0;
        else if (writeEnable && (rs1 == RD))
            readdata1 = wbdata;
        else
            readdata1 = regs[rs1];

        if (rs2 == 5'd0)
            readdata2 = 64'd0;
        else if (writeEnable && (rs2 == RD))
            readdata2 = wbdata;
        else
            readdata2 = regs[rs2];
    end

    // Register array: cleared on reset, one write per edge. Entry 0 is
    // never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 64'd0;
        end else if (writeEnable) begin
            regs[RD] <= wbdata;
        end
    end

    // Retirement counter and sticky fault flag. A faulting instruction does
    // not count as retired; the counter wraps naturally at 2^64.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret    <= 64'd0;
            load_fault <= 1'b0;
        end else if (wb_valid) begin
            if (fault)
                load_fault <= 1'b1;
            else
                instret <= instret + 64'd1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile
//
// Scoreboard bench for wb_regfile. The driver applies one transaction per
// cycle shortly after the rising edge, updates a behavioural model and pushes
// the expected outputs for that cycle into a queue. The monitor pops one entry
// on every falling edge and compares it with what the DUT presents.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        regwrite;
    logic        memtoreg;
    logic [63:0] alures;
    logic [63:0] readmem;
    logic [2:0]  funct3;
    logic [4:0]  RD;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] readdata1;
    logic [63:0] readdata2;
    logic [63:0] wbdata;
    logic [63:0] instret;
    logic        load_fault;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [63:0] mregs [32];
    logic [63:0] mcnt;
    logic        mfault;

    typedef struct {
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] wb;
        bit          chkwb;
        logic [63:0] cnt;
        logic        lf;
    } exp_t;

    exp_t expq[$];

    wb_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .regwrite   (regwrite),
        .memtoreg   (memtoreg),
        .alures     (alures),
        .readmem    (readmem),
        .funct3     (funct3),
        .RD         (RD),
        .rs1        (rs1),
        .rs2        (rs2),
        .readdata1  (readdata1),
        .readdata2  (readdata2),
        .wbdata     (wbdata),
        .instret    (instret),
        .load_fault (load_fault)
    );

    always #5 clk = ~clk;

    // Load value as the ISA describes it: take the addressed bytes, keep the
    // access width, then sign- or zero-extend.
    function automatic logic [63:0] modelLoad(input logic [63:0] mem,
                                              input logic [2:0] off,
                                              input logic [2:0] f3);
        int          nb;
        logic [63:0] sh;
        logic [63:0] mask;
        logic [63:0] v;
        nb = 1 << f3[1:0];
        sh = mem >> (8 * int'(off));
        if (nb == 8)
            return sh;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v = sh & mask;
        if (!f3[2] && sh[8 * nb - 1])
            v = v | ~mask;
        return v;
    endfunction

    function automatic logic modelFault(input logic [2:0] off, input logic [2:0] f3);
        int nb;
        nb = 1 << f3[1:0];
        return (f3 == 3'b111) || ((int'(off) % nb) != 0);
    endfunction

    function automatic logic [63:0] modelWb();
        return memtoreg ? modelLoad(readmem, alures[2:0], funct3) : alures;
    endfunction

    function automatic logic curFault();
        return memtoreg && modelFault(alures[2:0], funct3);
    endfunction

    // Apply the effect of the current inputs at a rising edge.
    task automatic commitModel();
        logic f;
        if (!reset) begin
            f = curFault();
            if (wb_valid && !f) begin
                mcnt = mcnt + 64'd1;
                if (regwrite && RD != 5'd0)
                    mregs[RD] = modelWb();
            end
            if (wb_valid && f)
                mfault = 1'b1;
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 32; i++)
            mregs[i] = 64'd0;
        mcnt   = 64'd0;
        mfault = 1'b0;
    endtask

    // Expected outputs for the inputs currently applied.
    task automatic pushExpect();
        exp_t        e;
        logic        f;
        logic        we;
        logic [63:0] wv;
        f  = curFault();
        wv = modelWb();
        we = wb_valid && regwrite && (RD != 5'd0) && !f;
        e.rd1   = (rs1 == 5'd0) ? 64'd0 : ((we && rs1 == RD) ? wv : mregs[rs1]);
        e.rd2   = (rs2 == 5'd0) ? 64'd0 : ((we && rs2 == RD) ? wv : mregs[rs2]);
        e.wb    = wv;
        e.chkwb = !f;
        e.cnt   = mcnt;
        e.lf    = mfault;
        expq.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic rw, input logic m2r,
                                 input logic [63:0] alu, input logic [63:0] mem,
                                 input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        commitModel();
        #1;
        wb_valid = wv;
        regwrite = rw;
        memtoreg = m2r;
        alures   = alu;
        readmem  = mem;
        funct3   = f3;
        RD       = rd;
        rs1      = r1;
        rs2      = r2;
        pushExpect();
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0, 5'd0, r1, r2);
    endtask

    // Asynchronous reset pulse in the middle of a cycle, spanning no edge.
    task automatic pulseReset(input logic [4:0] r1);
        @(posedge clk);
        commitModel();
        #1;
        wb_valid = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        rs1      = r1;
        rs2      = r1;
        reset    = 1'b1;
        clearModel();
        pushExpect();
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic forceCount(input logic [63:0] val);
        @(posedge clk);
        commitModel();
        #1;
        wb_valid = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        force dut.instret = val;
        mcnt = val;
        pushExpect();
        #1;
        release dut.instret;
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("readdata1", readdata1, e.rd1);
                checkOutput("readdata2", readdata2, e.rd2);
                if (e.chkwb)
                    checkOutput("wbdata", wbdata, e.wb);
                checkOutput("instret", instret, e.cnt);
                checkOutput("load_fault", {63'd0, load_fault}, {63'd0, e.lf});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    logic [2:0] loadF3  [7];
    logic [2:0] loadOff [7];

    initial begin
        reset    = 1'b1;
        wb_valid = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        alures   = 64'd0;
        readmem  = 64'd0;
        funct3   = 3'd0;
        RD       = 5'd0;
        rs1      = 5'd3;
        rs2      = 5'd4;
        clearModel();
        pushExpect();
        @(negedge clk);
        #2;
        reset = 1'b0;

        $display("[TB] ALU writeback and bypass");
        applyStimulus(1'b1, 1'b1, 1'b0, 64'hDEADBEEF_00000001, 64'd0, 3'd0, 5'd7, 5'd7, 5'd7);
        idle(5'd7, 5'd7);

        $display("[TB] load extraction");
        loadF3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110, 3'b011};
        loadOff = '{3'd7,   3'd7,   3'd2,   3'd6,   3'd4,   3'd4,   3'd0};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, {61'h20, loadOff[i]}, 64'h8877665544332211,
                          loadF3[i], 5'd10, 5'd10, 5'd0);
        end
        idle(5'd10, 5'd7);

        $display("[TB] faults");
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h9999, 64'd0, 3'd0, 5'd9, 5'd9, 5'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h1002, 64'h1122334455667788, 3'b010, 5'd9, 5'd9, 5'd9);
        idle(5'd9, 5'd9);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'hABCD, 64'd0, 3'b111, 5'd11, 5'd11, 5'd9);
        idle(5'd11, 5'd9);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h2000, 64'h5555, 3'b111, 5'd11, 5'd11, 5'd9);
        idle(5'd11, 5'd9);

        $display("[TB] x0 protection");
        applyStimulus(1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h1234, 64'd0, 3'd0, 5'd5, 5'd5, 5'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h1, 64'd0, 3'd0, 5'd6, 5'd5, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h2, 64'd0, 3'd0, 5'd6, 5'd5, 5'd0);
        idle(5'd5, 5'd5);
        pulseReset(5'd5);
        idle(5'd5, 5'd5);

        $display("[TB] back-to-back writes");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 64'h100 + 64'(i), 64'd0, 3'd0, 5'd12, 5'd12, 5'd12);
        idle(5'd12, 5'd12);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                          {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(5'd1, 5'd2);

        $display("[TB] counter wrap");
        forceCount(64'hFFFF_FFFF_FFFF_FFFE);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard drain actual=%0d required=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
